// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus responder: state encoding,
// parameter defaults, the latched request record and the window decode.
package m68k_bus_pkg;

  localparam logic [22:0] DEF_BASE_ADDR   = 23'h000000;
  localparam logic [22:0] DEF_ADDR_MASK   = 23'h7F0000;
  localparam int          DEF_WAIT_STATES = 0;
  localparam int          DEF_TIMEOUT     = 64;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCESS = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_ACK    = 3'd3;
  localparam logic [2:0] ST_BERR   = 3'd4;
  localparam logic [2:0] ST_TERM   = 3'd5;

  typedef struct packed {
    logic [22:0] addr;
    logic        rw;     // 1 = read
    logic [15:0] wdata;
    logic [1:0]  be;     // {upper, lower}
  } bus_req_t;

  function automatic logic in_window(input logic [22:0] a,
                                     input logic [22:0] base,
                                     input logic [22:0] mask);
    return (a & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/sync.sv
// Two-flop synchronizer for one asynchronous, idle-high bus strobe.
module sync (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/m68k_bus_responder.sv
// 68000 asynchronous bus slave bridging to a single-cycle-strobe local
// memory port, with address window decode, wait states and bus-error timeout.
module m68k_bus_responder
  import m68k_bus_pkg::*;
#(
  parameter logic [22:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [22:0] ADDR_MASK   = DEF_ADDR_MASK,
  parameter int          WAIT_STATES = DEF_WAIT_STATES,
  parameter int          TIMEOUT     = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [22:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic        ASn,
  input  logic        R_Wn,
  input  logic        UDSn,
  input  logic        LDSn,
  output logic        DTACKn,
  output logic        BERRn,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

  logic w_as_n, w_uds_n, w_lds_n;

  sync u_sync_as  (.clk(clk), .rstn(rstn), .i_d(ASn),  .o_q(w_as_n));
  sync u_sync_uds (.clk(clk), .rstn(rstn), .i_d(UDSn), .o_q(w_uds_n));
  sync u_sync_lds (.clk(clk), .rstn(rstn), .i_d(LDSn), .o_q(w_lds_n));

  logic [2:0]    r_state;
  bus_req_t      r_req;
  logic [15:0]   r_dout;
  logic          r_oe;
  logic          r_dtack_n;
  logic          r_berr_n;
  logic          r_re;
  logic          r_we;
  logic [TW-1:0] r_tcnt;
  logic [WW-1:0] r_wcnt;
  logic [1:0]    r_settle;
  logic          r_armed;

  logic [TW-1:0] w_tcnt_nxt;
  logic          w_tmo;
  logic          w_start;

  assign w_tcnt_nxt = r_tcnt + TW'(1);
  assign w_tmo      = (w_tcnt_nxt == TW'(TIMEOUT));
  assign w_start    = r_armed && !w_as_n && (!w_uds_n || !w_lds_n);

  // Synchronizers reset to "idle", so ASn is only trusted as high once they
  // have refilled from the real pins; this keeps a cycle that straddles
  // reset from being decoded.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_req     <= '0;
      r_dout    <= '0;
      r_oe      <= 1'b0;
      r_dtack_n <= 1'b1;
      r_berr_n  <= 1'b1;
      r_re      <= 1'b0;
      r_we      <= 1'b0;
      r_tcnt    <= '0;
      r_wcnt    <= '0;
      r_settle  <= '0;
      r_armed   <= 1'b0;
    end else begin
      r_re <= 1'b0;
      r_we <= 1'b0;
      if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
      else if (w_as_n)      r_armed  <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_armed <= 1'b0;
            r_req   <= '{addr: addr, rw: R_Wn, wdata: data_in,
                         be: {~w_uds_n, ~w_lds_n}};
            r_tcnt  <= '0;
            r_wcnt  <= '0;
            if (in_window(addr, BASE_ADDR, ADDR_MASK)) begin
              r_state <= ST_ACCESS;
              r_re    <= R_Wn;
              r_we    <= ~R_Wn;
            end else begin
              r_state <= ST_TERM;
            end
          end
        end

        ST_ACCESS: begin
          if (w_as_n) begin
            r_state <= ST_IDLE;
          end else if (w_tmo) begin
            r_state  <= ST_BERR;
            r_berr_n <= 1'b0;
          end else begin
            r_tcnt <= w_tcnt_nxt;
            if (mem_ready) begin
              r_dout <= mem_rdata;
              if (WAIT_STATES == 0) begin
                r_state   <= ST_ACK;
                r_dtack_n <= 1'b0;
                r_oe      <= r_req.rw;
              end else begin
                r_state <= ST_WAIT;
              end
            end
          end
        end

        ST_WAIT: begin
          if (w_as_n) begin
            r_state <= ST_IDLE;
          end else if (w_tmo) begin
            r_state  <= ST_BERR;
            r_berr_n <= 1'b0;
          end else begin
            r_tcnt <= w_tcnt_nxt;
            if (r_wcnt == WW'(WAIT_STATES - 1)) begin
              r_state   <= ST_ACK;
              r_dtack_n <= 1'b0;
              r_oe      <= r_req.rw;
            end else begin
              r_wcnt <= r_wcnt + WW'(1);
            end
          end
        end

        ST_ACK: begin
          if (w_as_n) begin
            r_state   <= ST_IDLE;
            r_dtack_n <= 1'b1;
            r_oe      <= 1'b0;
          end
        end

        ST_BERR: begin
          if (w_as_n) begin
            r_state  <= ST_IDLE;
            r_berr_n <= 1'b1;
          end
        end

        ST_TERM: begin
          if (w_as_n) r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_out  = r_dout;
  assign data_oe   = r_oe;
  assign DTACKn    = r_dtack_n;
  assign BERRn     = r_berr_n;
  assign mem_addr  = r_req.addr;
  assign mem_wdata = r_req.wdata;
  assign mem_be    = r_req.be;
  assign mem_re    = r_re;
  assign mem_we    = r_we;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Bench for m68k_bus_responder: a zero-wait and a three-wait-state instance
// share one bus and one local memory model kept in the bench.
module tb_m68k_bus_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [22:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] mem_rdata = '0;
  logic        ASn = 1'b1, R_Wn = 1'b1, UDSn = 1'b1, LDSn = 1'b1;
  logic        mem_ready = 1'b0;

  logic [1:0][15:0] dout, wdata;
  logic [1:0][22:0] maddr;
  logic [1:0][1:0]  be;
  logic [1:0]       oe, dtack_n, berr_n, re, we;

  always #5 clk = ~clk;

  m68k_bus_responder u_dut0 (
    .clk(clk), .rstn(rstn), .addr(addr), .data_in(data_in),
    .data_out(dout[0]), .data_oe(oe[0]),
    .ASn(ASn), .R_Wn(R_Wn), .UDSn(UDSn), .LDSn(LDSn),
    .DTACKn(dtack_n[0]), .BERRn(berr_n[0]),
    .mem_addr(maddr[0]), .mem_wdata(wdata[0]), .mem_be(be[0]),
    .mem_re(re[0]), .mem_we(we[0]),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  m68k_bus_responder #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .addr(addr), .data_in(data_in),
    .data_out(dout[1]), .data_oe(oe[1]),
    .ASn(ASn), .R_Wn(R_Wn), .UDSn(UDSn), .LDSn(LDSn),
    .DTACKn(dtack_n[1]), .BERRn(berr_n[1]),
    .mem_addr(maddr[1]), .mem_wdata(wdata[1]), .mem_be(be[1]),
    .mem_re(re[1]), .mem_we(we[1]),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int errors = 0;
  int checks = 0;
  int re_cnt [2] = '{0, 0};
  int we_cnt [2] = '{0, 0};
  logic [15:0] mem [64];

  // Strobe counting and the DTACKn/BERRn exclusivity rule, every cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (re[d]) re_cnt[d]++;
      if (we[d]) we_cnt[d]++;
      if (rstn) begin
        checks++;
        assert (!(dtack_n[d] === 1'b0 && berr_n[d] === 1'b0))
          else begin
            errors++;
            $error("FAIL dtack_berr_overlap dut%0d: both low", d);
          end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
  endtask

  task automatic start_cycle(input logic [22:0] a, input logic rw,
                             input logic [1:0] bl, input logic [15:0] din);
    addr = a; R_Wn = rw; data_in = din;
    ASn = 1'b0; UDSn = ~bl[1]; LDSn = ~bl[0];
  endtask

  task automatic end_cycle();
    ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; R_Wn = 1'b1;
    tick(5);
    for (int d = 0; d < 2; d++) begin
      chk("dtack_release", dtack_n[d], 1);
      chk("berr_release", berr_n[d], 1);
      chk("oe_release", oe[d], 0);
    end
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      tick(1);
      if (re[0] || we[0]) ok = 1'b1;
    end
    chk("strobe_seen", 32'(ok), 1);
  endtask

  // In-window access: local memory answers dly cycles after the strobe.
  task automatic do_access(input logic [22:0] a, input logic rw, input logic [1:0] bl,
                           input logic [15:0] din, input int dly);
    int s0 [2];
    int lat [2];
    bit ok;
    logic [15:0] exp;
    for (int d = 0; d < 2; d++) begin
      s0[d] = re_cnt[d] + we_cnt[d];
      lat[d] = 0;
    end
    start_cycle(a, rw, bl, din);
    wait_strobe(ok);
    if (ok) begin
      for (int d = 0; d < 2; d++) begin
        chk("mem_addr", 32'(maddr[d]), 32'(a));
        chk("mem_be", 32'(be[d]), 32'(bl));
        chk("mem_re", 32'(re[d]), 32'(rw));
        chk("mem_we", 32'(we[d]), 32'(!rw));
        if (!rw) chk("mem_wdata", 32'(wdata[d]), 32'(din));
      end
      tick(dly);
      exp = mem[a[5:0]];
      mem_ready = 1'b1; mem_rdata = exp;
      for (int k = 1; k <= 12; k++) begin
        tick(1);
        if (k == 1) begin
          mem_ready = 1'b0;
          mem_rdata = 16'($urandom);
        end
        for (int d = 0; d < 2; d++)
          if (lat[d] == 0 && dtack_n[d] == 1'b0) lat[d] = k;
      end
      chk("dtack_lat_ws0", 32'(lat[0]), 1);
      chk("dtack_lat_ws3", 32'(lat[1]), 4);
      for (int d = 0; d < 2; d++) begin
        chk("dtack_held", 32'(dtack_n[d]), 0);
        chk("berr_idle", 32'(berr_n[d]), 1);
        chk("data_oe", 32'(oe[d]), 32'(rw));
        if (rw) chk("data_out", 32'(dout[d]), 32'(exp));
      end
      if (!rw) begin
        if (bl[1]) mem[a[5:0]][15:8] = din[15:8];
        if (bl[0]) mem[a[5:0]][7:0]  = din[7:0];
      end
    end
    end_cycle();
    for (int d = 0; d < 2; d++)
      chk("strobe_count", 32'(re_cnt[d] + we_cnt[d] - s0[d]), 1);
  endtask

  task automatic do_oow(input logic [22:0] a);
    int s0 [2];
    for (int d = 0; d < 2; d++) s0[d] = re_cnt[d] + we_cnt[d];
    start_cycle(a, 1'b1, 2'b11, 16'h0);
    tick(12);
    for (int d = 0; d < 2; d++) begin
      chk("oow_dtack", 32'(dtack_n[d]), 1);
      chk("oow_berr", 32'(berr_n[d]), 1);
      chk("oow_oe", 32'(oe[d]), 0);
      chk("oow_strobes", 32'(re_cnt[d] + we_cnt[d] - s0[d]), 0);
    end
    end_cycle();
  endtask

  initial begin
    bit ok;
    bit dt;
    int lat [2];
    int s0 [2];
    logic [22:0] a;

    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    mem[16] = 16'hBEEF;

    rstn = 1'b0;
    tick(3);
    for (int d = 0; d < 2; d++) begin
      chk("rst_dtack", 32'(dtack_n[d]), 1);
      chk("rst_berr", 32'(berr_n[d]), 1);
      chk("rst_oe", 32'(oe[d]), 0);
      chk("rst_re_we", 32'({re[d], we[d]}), 0);
      chk("rst_mem_addr", 32'(maddr[d]), 0);
      chk("rst_mem_wdata", 32'(wdata[d]), 0);
      chk("rst_mem_be", 32'(be[d]), 0);
      chk("rst_data_out", 32'(dout[d]), 0);
    end
    rstn = 1'b1;
    tick(5);

    // Directed word read and byte write, then read back the merged word.
    do_access(23'h000010, 1'b1, 2'b11, 16'h0000, 1);
    do_access(23'h000020, 1'b0, 2'b01, 16'h00A5, 1);
    do_access(23'h000020, 1'b1, 2'b11, 16'h0000, 0);

    do_oow(23'h100000);

    // Timeout with no mem_ready: bus error 64 cycles after cycle start.
    start_cycle(23'h000005, 1'b1, 2'b11, 16'h0);
    wait_strobe(ok);
    lat = '{0, 0};
    dt = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      tick(1);
      for (int d = 0; d < 2; d++) begin
        if (lat[d] == 0 && berr_n[d] == 1'b0) lat[d] = k;
        if (dtack_n[d] == 1'b0) dt = 1'b1;
      end
    end
    chk("berr_lat_ws0", 32'(lat[0]), 64);
    chk("berr_lat_ws3", 32'(lat[1]), 64);
    chk("berr_no_dtack", 32'(dt), 0);
    end_cycle();

    // mem_ready landing on the timeout edge must lose.
    start_cycle(23'h000006, 1'b1, 2'b11, 16'h0);
    wait_strobe(ok);
    tick(63);
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    tick(1);
    mem_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("race_berr", 32'(berr_n[d]), 0);
      chk("race_dtack", 32'(dtack_n[d]), 1);
    end
    tick(6);
    for (int d = 0; d < 2; d++) chk("race_no_late_dtack", 32'(dtack_n[d]), 1);
    end_cycle();

    // Early ASn negation aborts without DTACKn.
    start_cycle(23'h000003, 1'b1, 2'b11, 16'h0);
    wait_strobe(ok);
    ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    dt = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (dtack_n != 2'b11) dt = 1'b1;
    end
    chk("abort_no_dtack", 32'(dt), 0);
    end_cycle();
    do_access(23'h000003, 1'b1, 2'b11, 16'h0, 2);

    // Reset during ACK with ASn held low.
    start_cycle(23'h000007, 1'b1, 2'b11, 16'h0);
    wait_strobe(ok);
    tick(1);
    mem_ready = 1'b1; mem_rdata = mem[7];
    tick(1);
    mem_ready = 1'b0;
    tick(5);
    for (int d = 0; d < 2; d++) chk("pre_rst_dtack", 32'(dtack_n[d]), 0);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk("midrst_dtack", 32'(dtack_n[d]), 1);
      chk("midrst_oe", 32'(oe[d]), 0);
      chk("midrst_mem_addr", 32'(maddr[d]), 0);
      chk("midrst_data_out", 32'(dout[d]), 0);
      s0[d] = re_cnt[d] + we_cnt[d];
    end
    tick(12);
    for (int d = 0; d < 2; d++) begin
      chk("held_as_ignored", 32'(re_cnt[d] + we_cnt[d] - s0[d]), 0);
      chk("held_as_dtack", 32'(dtack_n[d]), 1);
    end
    end_cycle();
    do_access(23'h000007, 1'b1, 2'b11, 16'h0, 1);

    // Randomized mix of reads, writes, byte lanes and out-of-window cycles.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        a = 23'h010000 | 23'($urandom_range(0, 16'hFFFF));
        do_oow(a);
      end else begin
        a = 23'($urandom_range(0, 63));
        do_access(a, 1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)),
                  16'($urandom), int'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
